cpu_fetch_unit: RTL and testbench

CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

---
 rtl/cpu_fetch_unit.sv | 83 ++++++++
 tb/tb_cpu_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: issues sequential 16-bit reads, redirects on branches,
// and parks one returning instruction in a skid register while decode is stalled.
module cpu_fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_stall,
   input  logic        i_br_en,
   input  logic [15:0] i_br_pc,
   output logic [15:0] o_imem_addr,
   output logic        o_imem_rd,
   input  logic [15:0] i_imem_rddata,
   output logic [15:0] o_ir,
   output logic [15:0] o_pc,
   output logic        o_valid
);

   // RUN means a read is in flight; HOLD means the skid register is occupied.
   // The two never coexist, because a read only issues when decode is not stalled.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_r;
   logic [15:0] pc_r;
   logic [15:0] inflight_pc_r;
   logic [15:0] skid_ir_r;
   logic [15:0] skid_pc_r;
   logic        issue_s;

   assign issue_s     = ~reset & ~i_br_en & ~i_stall;
   assign o_imem_rd   = issue_s;
   assign o_imem_addr = pc_r;

   // Fetch FSM: PC sequencing, in-flight tracking, skid buffer and decode-facing registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         pc_r          <= 16'h0000;
         inflight_pc_r <= 16'h0000;
         skid_ir_r     <= 16'h0000;
         skid_pc_r     <= 16'h0000;
         o_ir          <= 16'h0000;
         o_pc          <= 16'h0000;
         o_valid       <= 1'b0;
      end else if (i_br_en) begin
         // Branch wins over stall: drop in-flight and parked work, refetch from target
         pc_r    <= {i_br_pc[15:1], 1'b0};
         o_valid <= 1'b0;
         state_r <= IDLE;
      end else if (i_stall) begin
         case (state_r)
            RUN: begin
               skid_ir_r <= i_imem_rddata;
               skid_pc_r <= inflight_pc_r;
               state_r   <= HOLD;
            end
            IDLE:    state_r <= IDLE;
            HOLD:    state_r <= HOLD;
            default: state_r <= IDLE;
         endcase
      end else begin
         pc_r          <= pc_r + 16'd2;
         inflight_pc_r <= pc_r;
         state_r       <= RUN;
         case (state_r)
            HOLD: begin
               o_ir    <= skid_ir_r;
               o_pc    <= skid_pc_r;
               o_valid <= 1'b1;
            end
            RUN: begin
               o_ir    <= i_imem_rddata;
               o_pc    <= inflight_pc_r;
               o_valid <= 1'b1;
            end
            default: o_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: sequential fetch, stall/skid, branch,
// branch-during-hold, address wrap and asynchronous reset during a stall.
module tb_cpu_fetch_unit;

   logic        clk;
   logic        reset;
   logic        i_stall;
   logic        i_br_en;
   logic [15:0] i_br_pc;
   logic [15:0] o_imem_addr;
   logic        o_imem_rd;
   logic [15:0] i_imem_rddata;
   logic [15:0] o_ir;
   logic [15:0] o_pc;
   logic        o_valid;

   int checks = 0;
   int errors = 0;

   cpu_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .i_stall       (i_stall),
      .i_br_en       (i_br_en),
      .i_br_pc       (i_br_pc),
      .o_imem_addr   (o_imem_addr),
      .o_imem_rd     (o_imem_rd),
      .i_imem_rddata (i_imem_rddata),
      .o_ir          (o_ir),
      .o_pc          (o_pc),
      .o_valid       (o_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word at byte address k holds 0x1000 + k/2
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'h1000 + {1'b0, a[15:1]};
   endfunction

   // Synchronous memory: data valid the cycle after the read strobe, junk otherwise
   always @(posedge clk) begin
      if (o_imem_rd) i_imem_rddata <= mem_word(o_imem_addr);
      else           i_imem_rddata <= 16'hDEAD;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      i_stall = 1'b0;
      i_br_en = 1'b0;
      i_br_pc = 16'h0000;
      #2;
      chk("rst_valid", {15'd0, o_valid}, 16'h0000);
      chk("rst_pc",    o_pc,             16'h0000);
      chk("rst_ir",    o_ir,             16'h0000);
      chk("rst_addr",  o_imem_addr,      16'h0000);
      chk("rst_rd",    {15'd0, o_imem_rd}, 16'h0000);
      step(); step();

      // c0: first read of address 0
      step(); reset = 1'b0; #1;
      chk("c0_rd",   {15'd0, o_imem_rd}, 16'h0001);
      chk("c0_addr", o_imem_addr,        16'h0000);
      step();  // c1
      chk("c1_valid", {15'd0, o_valid}, 16'h0000);
      chk("c1_addr",  o_imem_addr,      16'h0002);
      step();  // c2
      chk("c2_valid", {15'd0, o_valid}, 16'h0001);
      chk("c2_pc",    o_pc,             16'h0000);
      chk("c2_ir",    o_ir,             16'h1000);
      step();  // c3
      chk("c3_pc", o_pc, 16'h0002);
      chk("c3_ir", o_ir, 16'h1001);
      step();  // c4
      chk("c4_pc", o_pc, 16'h0004);
      chk("c4_ir", o_ir, 16'h1002);

      // Stall three cycles (c4..c6) with o_pc at 0x0004
      i_stall = 1'b1; #1;
      chk("c4_stall_rd", {15'd0, o_imem_rd}, 16'h0000);
      step();  // c5
      chk("c5_pc", o_pc, 16'h0004);
      chk("c5_ir", o_ir, 16'h1002);
      chk("c5_rd", {15'd0, o_imem_rd}, 16'h0000);
      step();  // c6
      chk("c6_pc",    o_pc, 16'h0004);
      chk("c6_valid", {15'd0, o_valid}, 16'h0001);
      step();  // c7: release
      i_stall = 1'b0; #1;
      chk("c7_pc",   o_pc,        16'h0004);
      chk("c7_rd",   {15'd0, o_imem_rd}, 16'h0001);
      chk("c7_addr", o_imem_addr, 16'h0008);
      step();  // c8
      chk("c8_pc", o_pc, 16'h0006);
      chk("c8_ir", o_ir, 16'h1003);
      step();  // c9
      chk("c9_pc", o_pc, 16'h0008);
      chk("c9_ir", o_ir, 16'h1004);
      step();  // c10
      chk("c10_pc", o_pc, 16'h000A);

      // Branch to 0x0041 at c10 -> target 0x0040 delivered at c13
      i_br_en = 1'b1; i_br_pc = 16'h0041; #1;
      chk("br_rd_n", {15'd0, o_imem_rd}, 16'h0000);
      step();  // c11
      i_br_en = 1'b0; #1;
      chk("br_addr_n1",  o_imem_addr,      16'h0040);
      chk("br_valid_n1", {15'd0, o_valid}, 16'h0000);
      chk("br_rd_n1",    {15'd0, o_imem_rd}, 16'h0001);
      step();  // c12
      chk("br_valid_n2", {15'd0, o_valid}, 16'h0000);
      step();  // c13
      chk("br_valid_n3", {15'd0, o_valid}, 16'h0001);
      chk("br_pc_n3",    o_pc,             16'h0040);
      chk("br_ir_n3",    o_ir,             16'h1020);
      step();  // c14
      chk("br_pc_n4", o_pc, 16'h0042);
      chk("br_ir_n4", o_ir, 16'h1021);

      // Stall into HOLD, then branch + stall together: skid (0x0044) must vanish
      i_stall = 1'b1;
      step();  // c15 (HOLD)
      chk("hold_pc", o_pc, 16'h0042);
      step();  // c16
      i_br_en = 1'b1; i_br_pc = 16'h0081; #1;
      chk("hb_rd_n", {15'd0, o_imem_rd}, 16'h0000);
      step();  // c17
      i_br_en = 1'b0; i_stall = 1'b0; #1;
      chk("hb_addr_n1",  o_imem_addr,      16'h0080);
      chk("hb_valid_n1", {15'd0, o_valid}, 16'h0000);
      step();  // c18
      chk("hb_valid_n2", {15'd0, o_valid}, 16'h0000);
      step();  // c19
      chk("hb_valid_n3", {15'd0, o_valid}, 16'h0001);
      chk("hb_pc_n3",    o_pc,             16'h0080);
      chk("hb_ir_n3",    o_ir,             16'h1040);
      step();  // c20
      chk("hb_pc_n4", o_pc, 16'h0082);

      // Wrap: branch to 0xFFFF -> 0xFFFE then 0x0000
      i_br_en = 1'b1; i_br_pc = 16'hFFFF;
      step();  // c21
      i_br_en = 1'b0; #1;
      chk("wr_addr", o_imem_addr, 16'hFFFE);
      step();  // c22
      step();  // c23
      chk("wr_pc0", o_pc, 16'hFFFE);
      chk("wr_ir0", o_ir, 16'h8FFF);
      step();  // c24
      chk("wr_pc1", o_pc, 16'h0000);
      chk("wr_ir1", o_ir, 16'h1000);
      step();  // c25
      chk("wr_pc2", o_pc, 16'h0002);

      // Stall into HOLD, then asynchronous reset between clock edges
      i_stall = 1'b1;
      step();  // c26 (HOLD, skid = 0x0004)
      chk("rs_hold_pc", o_pc, 16'h0002);
      #1; reset = 1'b1; #1;
      chk("rs_valid", {15'd0, o_valid}, 16'h0000);
      chk("rs_pc",    o_pc,             16'h0000);
      chk("rs_ir",    o_ir,             16'h0000);
      chk("rs_addr",  o_imem_addr,      16'h0000);
      chk("rs_rd",    {15'd0, o_imem_rd}, 16'h0000);
      step();
      reset = 1'b0; i_stall = 1'b0; #1;
      chk("rs_c0_addr", o_imem_addr, 16'h0000);
      step();
      chk("rs_c1_valid", {15'd0, o_valid}, 16'h0000);
      step();
      chk("rs_c2_valid", {15'd0, o_valid}, 16'h0001);
      chk("rs_c2_pc",    o_pc,             16'h0000);
      chk("rs_c2_ir",    o_ir,             16'h1000);
      step();
      chk("rs_c3_pc", o_pc, 16'h0002);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
